// File: rtl/heap_root_ctrl.sv
// ---------------------------------------------------------------------------
// heap_root_ctrl
//
// Root stage of the pipelined heap sorter. The current minimum lives in a
// register (root). While filling, each new sample is compared against the
// root. The smaller value stays at the root and the larger one is pushed down
// to level 1 as an insert op. While draining, the root is presented on the
// output stream. Each time it is consumed, a delete-min op is sent to level 1,
// which later returns the replacement minimum.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   clk_en        global stall; nothing advances while low
//   in_*          input sample stream (valid/ready, last marks batch end)
//   out_*         sorted output stream, ascending (valid/ready, last)
//   low_out*      op towards level 1 (value, one-cycle strobe, 1 = delete)
//   low_in*       replacement minimum returned by level 1
//   ready_in      level 1 can accept a new op
//   err           sticky: level 1 returned a value that was not requested
// ---------------------------------------------------------------------------
module heap_root_ctrl #(
    parameter int DW     = 8,
    parameter int LEVELS = 4,
    parameter int CW     = $clog2(1 << (LEVELS + 1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic [DW-1:0] low_out,
    output logic          low_out_val,
    output logic          low_out_del,
    input  logic [DW-1:0] low_in,
    input  logic          low_in_val,
    input  logic          ready_in,
    output logic          err
);

    // Total capacity: root plus the levels beneath it.
    localparam int DEPTH = (1 << (LEVELS + 1)) - 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = '0;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [DW-1:0]   root_reg, root_next;
    logic [DW-1:0]   low_out_reg, low_out_next;
    logic            low_out_val_reg, low_out_val_next;
    logic            low_out_del_reg, low_out_del_next;
    logic            err_reg, err_next;

    // Conditions shared by the output decode and the next-state logic.
    logic            fill_open;
    logic            drain_fire;
    logic            count_is_zero;
    logic            count_is_one;
    logic            in_smaller;

    assign count_is_zero = (count_reg == ZERO_C);
    assign count_is_one  = (count_reg == ONE_C);

    // Tie goes to the incoming sample being pushed down, so a strict compare.
    assign in_smaller = (in_data < root_reg);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= FILL;
            count_reg       <= '0;
            root_reg        <= '0;
            low_out_reg     <= '0;
            low_out_val_reg <= 1'b0;
            low_out_del_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else if (clk_en) begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            root_reg        <= root_next;
            low_out_reg     <= low_out_next;
            low_out_val_reg <= low_out_val_next;
            low_out_del_reg <= low_out_del_next;
            err_reg         <= err_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        count_next       = count_reg;
        root_next        = root_reg;
        low_out_next     = low_out_reg;
        low_out_val_next = 1'b0;          // op strobe lasts one enabled cycle
        low_out_del_next = low_out_del_reg;
        err_next         = err_reg;

        // An insert needs level 1 ready only when something is pushed down,
        // i.e. when the root is already occupied.
        fill_open = (state_reg == FILL) && clk_en && !rst &&
                    (count_reg < DEPTH_C) && (count_is_zero || ready_in);

        // Consuming the root needs level 1 ready unless it is the last item,
        // because every other consume triggers a delete-min.
        drain_fire = (state_reg == DRAIN) && clk_en && out_ready &&
                     (count_is_one || ready_in);

        in_ready  = fill_open;
        out_valid = (state_reg == DRAIN);
        out_last  = (state_reg == DRAIN) && count_is_one;
        out_data  = root_reg;
        low_out   = low_out_reg;
        low_out_del = low_out_del_reg;
        // The registered strobe is held across a stall but hidden from level 1
        // so it is seen for exactly one enabled cycle.
        low_out_val = low_out_val_reg && clk_en;
        err         = err_reg;

        if (clk_en) begin
            unique case (state_reg)
                FILL: begin
                    if (low_in_val) begin
                        err_next = 1'b1;
                    end
                    if (in_valid && fill_open) begin
                        count_next = count_reg + ONE_C;
                        if (count_is_zero) begin
                            root_next = in_data;
                        end else begin
                            low_out_val_next = 1'b1;
                            low_out_del_next = 1'b0;
                            if (in_smaller) begin
                                root_next    = in_data;
                                low_out_next = root_reg;
                            end else begin
                                low_out_next = in_data;
                            end
                        end
                        if (in_last || (count_reg + ONE_C == DEPTH_C)) begin
                            state_next = DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (low_in_val) begin
                        err_next = 1'b1;
                    end
                    if (drain_fire) begin
                        if (count_is_one) begin
                            count_next = '0;
                            state_next = FILL;
                        end else begin
                            count_next       = count_reg - ONE_C;
                            low_out_val_next = 1'b1;
                            low_out_del_next = 1'b1;
                            state_next       = WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (low_in_val) begin
                        root_next  = low_in;
                        state_next = DRAIN;
                    end
                end

                default: begin
                    state_next = FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heap_root_ctrl.sv
// ---------------------------------------------------------------------------
// tb_heap_root_ctrl
//
// Directed bench for heap_root_ctrl. A small behavioural stand-in for level 1
// keeps the inserted values and answers each delete-min with the smallest one.
// Stimulus is driven just after the falling edge. Observers sample 3 time
// units later, which is ahead of the next rising edge.
// ---------------------------------------------------------------------------
module tb_heap_root_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 31;
    localparam int LAT   = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clk_en;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [DW-1:0] low_out;
    logic          low_out_val;
    logic          low_out_del;
    logic [DW-1:0] low_in;
    logic          low_in_val;
    logic          ready_in;
    logic          err;

    // Level-1 model drive and error-injection drive are kept separate.
    logic          m_val = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          inj_val = 1'b0;
    logic [DW-1:0] inj_data = '0;

    assign low_in_val = m_val | inj_val;
    assign low_in     = inj_val ? inj_data : m_data;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            op_cnt  = 0;

    logic [DW-1:0] out_log[$];
    bit            last_log[$];
    logic [DW-1:0] ins_log[$];
    logic [DW-1:0] store[$];

    always #5 clk = ~clk;

    heap_root_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .low_out    (low_out),
        .low_out_val(low_out_val),
        .low_out_del(low_out_del),
        .low_in     (low_in),
        .low_in_val (low_in_val),
        .ready_in   (ready_in),
        .err        (err)
    );

    // -------------------------------------------------------------------
    // Level-1 stand-in
    // -------------------------------------------------------------------
    int pend    = -1;
    bit m_clr   = 1'b0;
    bit m_start = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_clr) m_val = 1'b0;
            if (m_start && store.size() > 0) begin
                int mi;
                mi = 0;
                for (int k = 1; k < store.size(); k++)
                    if (store[k] < store[mi]) mi = k;
                m_data = store[mi];
                store.delete(mi);
                m_val = 1'b1;
            end
            m_clr   = 1'b0;
            m_start = 1'b0;
            #3;
            if (rst) begin
                store.delete();
                pend  = -1;
                m_clr = 1'b1;
            end else if (clk_en) begin
                if (m_val) m_clr = 1'b1;
                if (low_out_val) begin
                    if (!low_out_del) begin
                        store.push_back(low_out);
                        ins_log.push_back(low_out);
                    end else begin
                        pend = LAT;
                    end
                end else if (pend > 0) begin
                    pend--;
                end
                if (pend == 0) begin
                    m_start = 1'b1;
                    pend    = -1;
                end
            end
        end
    end

    // -------------------------------------------------------------------
    // Output collector: records each completed output handshake
    // -------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && clk_en && out_valid && out_ready && (out_last || ready_in)) begin
                out_log.push_back(out_data);
                last_log.push_back(out_last);
            end
            if (!rst && low_out_val) op_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge after the accept.
    task automatic send(input logic [DW-1:0] d, input bit last);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        t = 0;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("[TB] sent %0d last=%0d", d, last);
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (out_log.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("wait_out_size", 32'(out_log.size()), 32'(n));
    endtask

    task automatic clear_logs();
        out_log.delete();
        last_log.delete();
        ins_log.delete();
    endtask

    task automatic chk_seq5(input string tag);
        logic [DW-1:0] exp_out[5];
        logic [DW-1:0] exp_ins[4];
        exp_out = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9};
        exp_ins = '{8'd5, 8'd9, 8'd3, 8'd7};
        chk({tag, "_out_n"}, 32'(out_log.size()), 32'd5);
        if (out_log.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk({tag, "_out"}, 32'(out_log[k]), 32'(exp_out[k]));
                chk({tag, "_last"}, 32'(last_log[k]), 32'(k == 4));
                $display("[TB] %s out %0d = %0d last=%0d", tag, k, out_log[k], last_log[k]);
            end
        end
        chk({tag, "_ins_n"}, 32'(ins_log.size()), 32'd4);
        if (ins_log.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk({tag, "_ins"}, 32'(ins_log[k]), 32'(exp_ins[k]));
        end
    endtask

    // -------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------
    initial begin
        int ops0;
        int t;
        rst       = 1'b1;
        clk_en    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        ready_in  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_low_out_val", 32'(low_out_val), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1: basic batch 5,3,9,1,7
        clear_logs();
        ops0 = op_cnt;
        send(8'd5, 1'b0);
        send(8'd3, 1'b0);
        send(8'd9, 1'b0);
        send(8'd1, 1'b0);
        send(8'd7, 1'b1);
        #1;
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'd1);
        wait_out(5);
        #1;
        chk_seq5("t1");
        chk("t1_ops", 32'(op_cnt - ops0), 32'd8);
        chk("t1_back_fill", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 2: single sample
        clear_logs();
        ops0 = op_cnt;
        send(8'd42, 1'b1);
        #1;
        chk("t2_last_now", 32'(out_last), 32'd1);
        wait_out(1);
        #1;
        if (out_log.size() == 1) begin
            chk("t2_out", 32'(out_log[0]), 32'd42);
            chk("t2_last", 32'(last_log[0]), 32'd1);
        end
        chk("t2_no_ops", 32'(op_cnt - ops0), 32'd0);
        chk("t2_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 3: fill to capacity without in_last
        clear_logs();
        for (int i = 0; i < DEPTH; i++)
            send(8'((i * 7 + 3) % 31), 1'b0);
        #1;
        chk("t3_full_in_ready", 32'(in_ready), 32'd0);
        chk("t3_full_valid", 32'(out_valid), 32'd1);
        wait_out(DEPTH);
        if (out_log.size() == DEPTH) begin
            for (int k = 0; k < DEPTH; k++)
                chk("t3_out", 32'(out_log[k]), 32'(k));
            chk("t3_last_end", 32'(last_log[DEPTH-1]), 32'd1);
            chk("t3_last_prev", 32'(last_log[DEPTH-2]), 32'd0);
        end
        @(negedge clk);

        // 4: duplicates
        clear_logs();
        send(8'd4, 1'b0);
        send(8'd4, 1'b0);
        send(8'd4, 1'b1);
        wait_out(3);
        if (out_log.size() == 3)
            for (int k = 0; k < 3; k++) chk("t4_out", 32'(out_log[k]), 32'd4);
        chk("t4_ins_n", 32'(ins_log.size()), 32'd2);
        if (ins_log.size() == 2)
            for (int k = 0; k < 2; k++) chk("t4_ins", 32'(ins_log[k]), 32'd4);
        @(negedge clk);

        // 5: stalls mid-fill, in DRAIN (ready_in low) and mid-WAIT
        clear_logs();
        send(8'd5, 1'b0);
        send(8'd3, 1'b0);
        clk_en   = 1'b0;
        in_data  = 8'd9;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_fill_stall_ready", 32'(in_ready), 32'd0);
            chk("t5_fill_stall_op", 32'(low_out_val), 32'd0);
            @(negedge clk);
        end
        clk_en = 1'b1;
        #1;
        chk("t5_resume_op", 32'(low_out_val), 32'd1);
        chk("t5_resume_val", 32'(low_out), 32'd5);
        send(8'd9, 1'b0);
        send(8'd1, 1'b0);
        send(8'd7, 1'b1);
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_data", 32'(out_data), 32'd1);
            @(negedge clk);
        end
        chk("t5_hold_none", 32'(out_log.size()), 32'd0);
        ready_in = 1'b1;
        t = 0;
        @(negedge clk);
        #1;
        while (out_valid && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("t5_in_wait", 32'(out_valid), 32'd0);
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("t5_wait_stall_op", 32'(low_out_val), 32'd0);
            chk("t5_wait_stall_valid", 32'(out_valid), 32'd0);
        end
        clk_en = 1'b1;
        wait_out(5);
        #1;
        chk_seq5("t5");
        chk("t5_err_clear", 32'(err), 32'd0);
        @(negedge clk);

        // 6: spurious low_in_val sets err; reset mid-drain
        inj_data = 8'hAA;
        inj_val  = 1'b1;
        @(negedge clk);
        inj_val = 1'b0;
        #1;
        chk("t6_err_set", 32'(err), 32'd1);
        @(negedge clk);
        #1;
        chk("t6_err_sticky", 32'(err), 32'd1);
        @(negedge clk);
        clear_logs();
        send(8'd5, 1'b0);
        send(8'd3, 1'b0);
        send(8'd9, 1'b0);
        send(8'd1, 1'b0);
        send(8'd7, 1'b1);
        wait_out(1);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_last", 32'(out_last), 32'd0);
        chk("t6_rst_out_data", 32'(out_data), 32'd0);
        chk("t6_rst_low_out", 32'(low_out), 32'd0);
        chk("t6_rst_low_out_val", 32'(low_out_val), 32'd0);
        chk("t6_rst_low_out_del", 32'(low_out_del), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_fill_after_rst", 32'(in_ready), 32'd1);
        @(negedge clk);
        clear_logs();
        send(8'd6, 1'b1);
        wait_out(1);
        if (out_log.size() == 1) begin
            chk("t6_fresh_out", 32'(out_log[0]), 32'd6);
            chk("t6_fresh_last", 32'(last_log[0]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/heap_root_ctrl.md
# heap_root_ctrl

Root stage of the pipelined heap sorter: holds the current minimum in a register and feeds the first `sorter_ctrl` level beneath it. It accepts an input stream of samples (fill phase), pushes displaced larger values down the pipeline as insert ops, then drains the sorted stream (ascending) by emitting the root and refilling it via delete ops to level 1. It sits between the pixel/sample source and the top `sorter_ctrl`.

## Interface
- `DW`, 8: sample width.
- `LEVELS`, 4: number of `sorter_ctrl` levels below root; capacity `DEPTH = 2^(LEVELS+1)-1`.
- `CW`, `$clog2(DEPTH+1)`: occupancy counter width.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clk_en`  in  1  global stall; state advances only when 1.
- `in_data`  in  DW  sample to sort.
- `in_valid`  in  1  sample present.
- `in_last`  in  1  final sample of the batch.
- `in_ready`  out  1  sample accepted when `in_valid & in_ready & clk_en`.
- `out_data`  out  DW  sorted sample (root).
- `out_valid`  out  1  `out_data` valid.
- `out_last`  out  1  last sorted sample of the batch.
- `out_ready`  in  1  consumer accepts.
- `low_out`  out  DW  value sent to level 1.
- `low_out_val`  out  1  one-cycle op strobe to level 1.
- `low_out_del`  out  1  op type: 0 = insert `low_out`, 1 = delete-min.
- `low_in`  in  DW  replacement minimum returned by level 1.
- `low_in_val`  in  1  `low_in` valid (one cycle).
- `ready_in`  in  1  level 1 can take a new op.
- `err`  out  1  sticky protocol error.

## Operation
- States: FILL, DRAIN, WAIT.
- FILL: `in_ready = clk_en & (count < DEPTH) & (count == 0 | ready_in)`.
  - Accept with `count == 0`: root <= `in_data`; no down op.
  - Accept with `count > 0`: compare unsigned; smaller stays/becomes root, larger goes down as insert (`low_out_del = 0`). Tie: incoming value goes down.
  - `count <= count + 1`.
  - Move to DRAIN when `in_last` is accepted or `count` reaches DEPTH after the accept.
  - `in_last` accepted with `count == 0` cannot occur (the accept itself makes count 1).
- DRAIN: `out_valid = 1`, `out_data = root`, `out_last = (count == 1)`.
  - On `out_ready & clk_en` with `count == 1`: count <= 0, go to FILL.
  - On `out_ready & clk_en` with `count > 1` and `ready_in`: issue delete (`low_out_del = 1`), count <= count - 1, go to WAIT.
  - If `ready_in = 0`, the handshake is not completed; `out_valid` stays high and root is held. Effective `out_ready` = `out_ready & (count == 1 | ready_in)`.
- WAIT: `out_valid = 0`. On `low_in_val & clk_en`: root <= `low_in`, go to DRAIN.
- Errors and stalls:
  - `low_in_val` in FILL or DRAIN sets `err`; the value is ignored. `err` clears only on `rst`.
  - `clk_en = 0`: all registers hold, `in_ready = 0`, `low_out_val = 0`; `out_valid`/`out_data` hold their values but no handshake completes.
- Reset values: state FILL, count 0, root 0, `in_ready` 0 during `rst`, `out_valid` 0, `out_last` 0, `out_data` 0, `low_out` 0, `low_out_val` 0, `low_out_del` 0, `err` 0.
- Reset mid-batch discards all contents. Level registers share `rst`.

## Timing
- Down ops are registered: `low_out`/`low_out_val`/`low_out_del` assert the cycle after the accepting edge, for exactly one `clk_en` cycle.
- First `out_valid` is asserted the cycle after the `in_last` accept.
- Root refills the cycle after `low_in_val`; `out_valid` rises on that same cycle.
- Minimum throughput:
  - Fill: 1 sample/cycle while `ready_in` is high.
  - Drain: one output per (2 + level-1 return latency) cycles.
- At most one op is outstanding to level 1; no new op is issued in WAIT.

## Test plan
- Fill 5,3,9,1,7 (`in_last` on 7), `out_ready` = 1 -> outputs 1,3,5,7,9; `out_last` only with 9; down inserts carry 5,9,3,7 in that order.
- Single sample 42 with `in_last` -> one output 42 with `out_last = 1`, no `low_out_val` pulse; returns to FILL with `in_ready` = 1.
- Fill DEPTH samples without `in_last` -> `in_ready` drops after the DEPTH-th accept, DRAIN entered, DEPTH outputs ascending.
- Duplicates 4,4,4 -> outputs 4,4,4; each down insert carries 4.
- Drop `clk_en` for 3 cycles mid-fill and mid-WAIT; hold `ready_in` = 0 in DRAIN -> no accepts or ops during the stall, `out_valid` held high, output sequence identical to the unstalled run.
- Pulse `low_in_val` in FILL -> `err` = 1 and stays 1; assert `rst` mid-drain -> all outputs 0, state FILL, `err` = 0 next cycle.
